// File: rtl/tank_plant_model.sv
// Water tank plant emulator: integrates pump inflow minus drain into a saturating
// level, and reports level sensors, a sticky overflow fault and dry-drain pulses.
module tank_plant_model #(
  parameter int LEVEL_W    = 8,
  parameter int MAX_LEVEL  = 200,
  parameter int LOW_TH     = 50,
  parameter int HIGH_TH    = 150,
  parameter int PUMP_RATE  = 2,
  parameter int DRAIN_RATE = 1,
  parameter int TICK_DIV   = 4,
  parameter int INIT_LEVEL = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         pumps,
  input  logic               drain_en,
  output logic [1:0]         sensors,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic               dry_pulse,
  output logic [1:0]         plant_state
);

  localparam int NW    = LEVEL_W + 2;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic signed [NW-1:0] MAX_S = NW'(MAX_LEVEL);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'b00,
    ST_NORMAL   = 2'b01,
    ST_FULL     = 2'b10,
    ST_OVERFLOW = 2'b11
  } state_t;

  function automatic logic [1:0] sens_of(input logic [LEVEL_W-1:0] l);
    return {l >= LEVEL_W'(HIGH_TH), l >= LEVEL_W'(LOW_TH)};
  endfunction

  function automatic state_t state_of(input logic [LEVEL_W-1:0] l);
    if (l >= LEVEL_W'(HIGH_TH))     return ST_FULL;
    else if (l >= LEVEL_W'(LOW_TH)) return ST_NORMAL;
    else                            return ST_EMPTY;
  endfunction

  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [1:0]         sensors_q, sensors_d;
  logic               overflow_q, overflow_d;
  logic               dry_q, dry_d;
  state_t             state_q, state_d;

  logic                 tick;
  logic signed [NW-1:0] fill_s, drn_s, sum_s;
  logic [LEVEL_W-1:0]   clamped;
  logic                 clamp_hi;

  assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

  // Signed arithmetic two bits wider than the level so neither drain below zero
  // nor fill above MAX_LEVEL can wrap before the clamp sees it.
  always_comb begin
    fill_s   = NW'(PUMP_RATE) * NW'({1'b0, pumps[0]} + {1'b0, pumps[1]});
    drn_s    = drain_en ? NW'(DRAIN_RATE) : '0;
    sum_s    = $signed({2'b00, level_q}) + fill_s - drn_s;
    clamp_hi = 1'b0;
    if (sum_s < 0) begin
      clamped = '0;
    end else if (sum_s > MAX_S) begin
      clamped  = LEVEL_W'(MAX_LEVEL);
      clamp_hi = 1'b1;
    end else begin
      clamped = sum_s[LEVEL_W-1:0];
    end
  end

  always_comb begin
    pre_d      = pre_q + 1'b1;
    level_d    = level_q;
    sensors_d  = sensors_q;
    overflow_d = overflow_q;
    state_d    = state_q;
    dry_d      = 1'b0;
    if (tick) begin
      pre_d     = '0;
      level_d   = clamped;
      sensors_d = sens_of(clamped);
      dry_d     = drain_en && (level_q == '0);
      if (clamp_hi || state_q == ST_OVERFLOW) begin
        overflow_d = 1'b1;
        state_d    = ST_OVERFLOW;
      end else begin
        state_d = state_of(clamped);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre_q      <= '0;
      level_q    <= LEVEL_W'(INIT_LEVEL);
      sensors_q  <= sens_of(LEVEL_W'(INIT_LEVEL));
      overflow_q <= 1'b0;
      dry_q      <= 1'b0;
      state_q    <= state_of(LEVEL_W'(INIT_LEVEL));
    end else begin
      pre_q      <= pre_d;
      level_q    <= level_d;
      sensors_q  <= sensors_d;
      overflow_q <= overflow_d;
      dry_q      <= dry_d;
      state_q    <= state_d;
    end
  end

  assign sensors     = sensors_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign dry_pulse   = dry_q;
  assign plant_state = state_q;

endmodule

// File: tb/tb_tank_plant_model.sv
// Directed closed-form bench for tank_plant_model: a cycle-level model checked on every
// falling edge, plus hand-computed literal checkpoints along the fill/drain scenario.
module tb_tank_plant_model;

  localparam int LW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    pumps = 2'b00;
  logic          drain_en = 1'b0;
  logic [1:0]    sensors;
  logic [LW-1:0] level;
  logic          overflow;
  logic          dry_pulse;
  logic [1:0]    plant_state;

  int checks = 0;
  int errors = 0;

  tank_plant_model dut (
    .clock(clock), .reset(reset), .pumps(pumps), .drain_en(drain_en),
    .sensors(sensors), .level(level), .overflow(overflow),
    .dry_pulse(dry_pulse), .plant_state(plant_state)
  );

  always #5 clock = ~clock;

  // Model: level as a plain integer, ticks every 4th edge since reset release.
  int m_level = 0;
  int m_cyc   = 0;
  int m_ovf   = 0;
  int m_dry   = 0;

  always @(posedge clock) begin
    int net, raw;
    if (!reset) begin
      m_level = 0; m_cyc = 0; m_ovf = 0; m_dry = 0;
    end else begin
      m_dry = 0;
      if (m_cyc % 4 == 3) begin
        net = 2 * (int'(pumps[0]) + int'(pumps[1])) - (drain_en ? 1 : 0);
        raw = m_level + net;
        if (raw > 200) begin raw = 200; m_ovf = 1; end
        if (raw < 0) raw = 0;
        m_dry   = (drain_en && m_level == 0) ? 1 : 0;
        m_level = raw;
      end
      m_cyc++;
    end
  end

  function automatic logic [1:0] exp_sens(int l);
    return {l >= 150, l >= 50};
  endfunction

  function automatic logic [1:0] exp_state(int l, int ovf);
    if (ovf != 0) return 2'b11;
    if (l >= 150) return 2'b10;
    if (l >= 50)  return 2'b01;
    return 2'b00;
  endfunction

  bit chk_en = 1'b0;

  always @(negedge clock) begin
    logic [12:0] act, exp;
    if (chk_en) begin
      act = {level, sensors, overflow, dry_pulse, plant_state};
      exp = {LW'(m_level), exp_sens(m_level), m_ovf != 0, m_dry != 0,
             exp_state(m_level, m_ovf)};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t level=%0d/%0d sensors=%b/%b ovf=%b/%b dry=%b/%b state=%b/%b",
                 $time, level, m_level, sensors, exp_sens(m_level), overflow, m_ovf != 0,
                 dry_pulse, m_dry != 0, plant_state, exp_state(m_level, m_ovf));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic lit_all(input string name, input int lv, input int se, input int ov, input int st);
    lit({name, "_level"}, int'(level), lv);
    lit({name, "_sensors"}, int'(sensors), se);
    lit({name, "_ovf"}, int'(overflow), ov);
    lit({name, "_state"}, int'(plant_state), st);
  endtask

  initial begin
    int dry_cnt;
    // 1: reset two edges, then idle
    cyc(1);
    chk_en = 1'b1;
    lit_all("reset", 0, 0, 0, 0);
    cyc(1);
    reset = 1'b1;
    cyc(40);
    lit_all("idle40", 0, 0, 0, 0);

    // 2: one pump fills +2 per tick
    pumps = 2'b01;
    cyc(99);
    lit_all("fill_c99", 48, 0, 0, 0);
    cyc(1);
    lit_all("fill_c100", 50, 1, 0, 1);

    // 3: both pumps to the high threshold, then fill and drain together
    pumps = 2'b11;
    cyc(100);
    lit_all("high150", 150, 3, 0, 2);
    pumps = 2'b01; drain_en = 1'b1;
    cyc(4);
    lit_all("mix151", 151, 3, 0, 2);
    pumps = 2'b00;
    cyc(4);
    lit("drain150", int'(level), 150);

    // 4: approach the top, land exactly on MAX, then clamp into overflow
    pumps = 2'b11; drain_en = 1'b0;
    cyc(48);
    lit_all("top198", 198, 3, 0, 2);
    pumps = 2'b01;
    cyc(4);
    lit_all("exact200", 200, 3, 0, 2);
    pumps = 2'b11;
    cyc(4);
    lit_all("clamp200", 200, 3, 1, 3);
    pumps = 2'b00; drain_en = 1'b1;
    cyc(8);
    lit_all("sticky198", 198, 3, 1, 3);

    // 5: drain from empty produces one dry pulse per tick
    reset = 1'b0;
    cyc(1);
    lit_all("rst2", 0, 0, 0, 0);
    reset = 1'b1;
    dry_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      if (dry_pulse) dry_cnt++;
    end
    lit("dry_count", dry_cnt, 3);
    lit("dry_level", int'(level), 0);

    // 6: reset mid-tick from level 120
    drain_en = 1'b0; pumps = 2'b11;
    cyc(120);
    lit("lvl120", int'(level), 120);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    lit_all("midrst", 0, 0, 0, 0);
    cyc(5);
    lit("rst_hold", int'(level), 0);
    reset = 1'b1; pumps = 2'b01;
    cyc(3);
    lit("post_rst3", int'(level), 0);
    cyc(1);
    lit("post_rst4", int'(level), 2);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
